// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Pipeline constants shared by the hazard controller and its HI/LO occupancy
// counter: default multi-cycle latencies, interrupt FSM encoding, and the
// hard-wired zero register number.
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAKE = 2'd1,
    ST_HOLD = 2'd2
  } int_state_e;

  // True when a nonzero destination matches a source register the ID
  // instruction actually reads. Writes to $0 are discarded, so never a hazard.
  function automatic logic src_match(
    input logic       use_rs,
    input logic [4:0] rs,
    input logic       use_rt,
    input logic [4:0] rt,
    input logic [4:0] wr
  );
    logic hit;
    hit = (use_rs && (rs == wr)) || (use_rt && (rt == wr));
    return hit && (wr != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// -----------------------------------------------------------------------------
// md_busy_cnt
// Loadable countdown tracking HI/LO occupancy after a MULT/DIV issues.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (clears the count)
//   start_i  MULT/DIV enters EX this cycle
//   is_div_i qualifies start_i: 1 = DIV latency, 0 = MULT latency
//   busy_o   count is nonzero (derived from the register only)
// -----------------------------------------------------------------------------
module md_busy_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             nonzero_s;

  assign nonzero_s = (cnt_q != {CNT_W{1'b0}});
  assign busy_o    = nonzero_s;

  // Next count: a start only loads from idle; a start while counting is
  // ignored and the countdown simply continues, saturating at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (nonzero_s) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (start_i) begin
      if (is_div_i) begin
        cnt_d = CNT_W'(DIV_LAT);
      end else begin
        cnt_d = CNT_W'(MULT_LAT);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Count register; reset discards any pending occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Sequencing controller for the 5-stage MIPS pipeline. Detects load-use,
// branch-operand and HI/LO-busy hazards, and runs interrupt entry.
// Ports:
//   clk, rst                       clock / async active-low reset
//   id_rs, id_rt, id_use_rs/rt     ID source registers and their use flags
//   id_is_branch, id_is_md         ID instruction class
//   br_taken                       branch resolved taken in ID
//   ex_mem_read, ex_reg_write      EX instruction is a load / writes GPRs
//   ex_wr_reg                      EX destination register
//   md_start, md_is_div            MULT/DIV issue into EX
//   int_req                        level interrupt request
//   pc_en, if_id_en                PC / IF-ID write enables
//   if_id_flush, id_ex_flush       IF/ID clear, ID/EX bubble insert
//   md_busy                        HI/LO unit occupied
//   int_ack                        one-cycle interrupt accept pulse
// All outputs are combinational from state plus inputs and forced low in reset.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_is_branch,
  input  logic       id_is_md,
  input  logic       br_taken,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_wr_reg,
  input  logic       md_start,
  input  logic       md_is_div,
  input  logic       int_req,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       md_busy,
  output logic       int_ack
);

  int_state_e state_q;
  int_state_e state_d;

  logic match_s;
  logic lu_s;
  logic bh_s;
  logic mh_s;
  logic stall_s;
  logic md_busy_s;

  md_busy_cnt #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_cnt (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .is_div_i (md_is_div),
    .busy_o   (md_busy_s)
  );

  assign match_s = src_match(id_use_rs, id_rs, id_use_rt, id_rt, ex_wr_reg);
  assign lu_s    = ex_mem_read & match_s;
  // A branch compares in ID, so even an ALU result still in EX is too late.
  assign bh_s    = id_is_branch & ex_reg_write & match_s;
  assign mh_s    = id_is_md & md_busy_s;
  assign stall_s = lu_s | bh_s | mh_s;
  assign md_busy = md_busy_s;

  // Hazard outputs and interrupt FSM next state. A stalled branch is not yet
  // resolved, so its flush waits; TAKE overrides everything for one cycle so
  // the PC picks up the handler vector and both front stages are squashed.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    int_ack     = 1'b0;
    if (!rst) begin
      state_d = ST_IDLE;
    end else begin
      pc_en       = ~stall_s;
      if_id_en    = ~stall_s;
      id_ex_flush = stall_s;
      if_id_flush = br_taken & ~stall_s;
      case (state_q)
        ST_IDLE: begin
          // A request arriving during a stall stays pending here.
          if (int_req && !stall_s) begin
            state_d = ST_TAKE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_TAKE: begin
          int_ack     = 1'b1;
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = ST_HOLD;
        end
        ST_HOLD: begin
          // Level request is taken once; wait for it to drop before rearming.
          if (!int_req) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Interrupt FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_is_branch;
  logic       id_is_md;
  logic       br_taken;
  logic       ex_mem_read;
  logic       ex_reg_write;
  logic [4:0] ex_wr_reg;
  logic       md_start;
  logic       md_is_div;
  logic       int_req;
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       md_busy;
  logic       int_ack;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_is_branch (id_is_branch),
    .id_is_md     (id_is_md),
    .br_taken     (br_taken),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_wr_reg    (ex_wr_reg),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .int_req      (int_req),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .md_busy      (md_busy),
    .int_ack      (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_is_branch = 1'b0; id_is_md = 1'b0; br_taken = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_wr_reg = 5'd0;
    md_start = 1'b0; md_is_div = 1'b0; int_req = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // ---------------- reset with arbitrary inputs ----------------
    rst = 1'b0;
    clear_inputs();
    ex_mem_read = 1'b1; ex_wr_reg = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    br_taken = 1'b1; int_req = 1'b1; md_start = 1'b1; id_is_md = 1'b1;
    next_cycle(); settle();
    check("rst_pc_en", pc_en, 1'b0);
    check("rst_if_id_en", if_id_en, 1'b0);
    check("rst_if_id_flush", if_id_flush, 1'b0);
    check("rst_id_ex_flush", id_ex_flush, 1'b0);
    check("rst_md_busy", md_busy, 1'b0);
    check("rst_int_ack", int_ack, 1'b0);
    next_cycle(); settle();
    check("rst_md_busy_2", md_busy, 1'b0);

    next_cycle();
    clear_inputs();
    rst = 1'b1;
    settle();
    next_cycle(); settle();
    check("rel_pc_en", pc_en, 1'b1);
    check("rel_if_id_en", if_id_en, 1'b1);
    check("rel_id_ex_flush", id_ex_flush, 1'b0);
    check("rel_int_ack", int_ack, 1'b0);

    // ---------------- load-use ----------------
    next_cycle();
    ex_mem_read = 1'b1; ex_wr_reg = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    settle();
    check("lu_pc_en", pc_en, 1'b0);
    check("lu_if_id_en", if_id_en, 1'b0);
    check("lu_id_ex_flush", id_ex_flush, 1'b1);
    next_cycle();
    ex_mem_read = 1'b0; ex_wr_reg = 5'd0;  // bubble now in EX
    settle();
    check("lu_end_pc_en", pc_en, 1'b1);
    check("lu_end_id_ex_flush", id_ex_flush, 1'b0);
    next_cycle();
    ex_mem_read = 1'b1; ex_wr_reg = 5'd0; id_rs = 5'd0;
    settle();
    check("lu_r0_pc_en", pc_en, 1'b1);
    check("lu_r0_id_ex_flush", id_ex_flush, 1'b0);
    next_cycle();
    id_use_rs = 1'b0; id_use_rt = 1'b1; id_rt = 5'd12; ex_wr_reg = 5'd12;
    settle();
    check("lu_rt_pc_en", pc_en, 1'b0);
    next_cycle();
    id_use_rt = 1'b0;
    settle();
    check("lu_rt_unused_pc_en", pc_en, 1'b1);

    // ---------------- branch with ALU producer in EX ----------------
    next_cycle();
    clear_inputs();
    id_is_branch = 1'b1; id_rt = 5'd9; id_use_rt = 1'b1;
    ex_reg_write = 1'b1; ex_wr_reg = 5'd9; br_taken = 1'b1;
    settle();
    check("bh_pc_en", pc_en, 1'b0);
    check("bh_id_ex_flush", id_ex_flush, 1'b1);
    check("bh_if_id_flush", if_id_flush, 1'b0);
    next_cycle();
    ex_reg_write = 1'b0; ex_wr_reg = 5'd0;
    settle();
    check("bh_res_if_id_flush", if_id_flush, 1'b1);
    check("bh_res_pc_en", pc_en, 1'b1);
    check("bh_res_id_ex_flush", id_ex_flush, 1'b0);
    next_cycle();
    id_is_branch = 1'b0; br_taken = 1'b0; ex_reg_write = 1'b1; ex_wr_reg = 5'd9;
    settle();
    check("alu_nonbranch_pc_en", pc_en, 1'b1);

    // ---------------- MULT then mflo (start ignored while busy) ----------------
    next_cycle();
    clear_inputs();
    md_start = 1'b1; md_is_div = 1'b0;
    settle();
    check("mult_t_md_busy", md_busy, 1'b0);
    check("mult_t_pc_en", pc_en, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      md_start = (k == 2);
      md_is_div = (k == 2);
      id_is_md = 1'b1;
      settle();
      check($sformatf("mult_busy_t%0d", k), md_busy, (k <= 5));
      check($sformatf("mult_pc_en_t%0d", k), pc_en, (k > 5));
      check($sformatf("mult_flush_t%0d", k), id_ex_flush, (k <= 5));
    end

    // ---------------- DIV then mfhi ----------------
    next_cycle();
    clear_inputs();
    md_start = 1'b1; md_is_div = 1'b1;
    settle();
    for (int k = 1; k <= 11; k++) begin
      next_cycle();
      md_start = 1'b0; md_is_div = 1'b0; id_is_md = 1'b1;
      settle();
      check($sformatf("div_busy_t%0d", k), md_busy, (k <= 10));
      check($sformatf("div_pc_en_t%0d", k), pc_en, (k > 10));
    end

    // ---------------- interrupt during a load-use stall ----------------
    next_cycle();
    clear_inputs();
    int_req = 1'b1; ex_mem_read = 1'b1; ex_wr_reg = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    settle();
    check("int_stall1_ack", int_ack, 1'b0);
    check("int_stall1_pc_en", pc_en, 1'b0);
    next_cycle(); settle();
    check("int_stall2_ack", int_ack, 1'b0);
    next_cycle();
    ex_mem_read = 1'b0; ex_wr_reg = 5'd0;
    settle();
    check("int_clear_ack", int_ack, 1'b0);
    check("int_clear_pc_en", pc_en, 1'b1);
    next_cycle(); settle();
    check("int_take_ack", int_ack, 1'b1);
    check("int_take_if_id_flush", if_id_flush, 1'b1);
    check("int_take_id_ex_flush", id_ex_flush, 1'b1);
    check("int_take_pc_en", pc_en, 1'b1);
    next_cycle(); settle();
    check("int_hold1_ack", int_ack, 1'b0);
    check("int_hold1_if_id_flush", if_id_flush, 1'b0);
    next_cycle(); settle();
    check("int_hold2_ack", int_ack, 1'b0);
    next_cycle();
    int_req = 1'b0;
    settle();
    check("int_drop_ack", int_ack, 1'b0);
    next_cycle();
    int_req = 1'b1;
    settle();
    check("int_rearm_ack", int_ack, 1'b0);
    next_cycle(); settle();
    check("int_second_ack", int_ack, 1'b1);
    next_cycle();
    int_req = 1'b0;
    settle();
    check("int_second_done_ack", int_ack, 1'b0);

    // ---------------- reset in the middle of a DIV ----------------
    next_cycle();
    clear_inputs();
    md_start = 1'b1; md_is_div = 1'b1;
    settle();
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      md_start = 1'b0;
      settle();
      check($sformatf("rdiv_busy_t%0d", k), md_busy, 1'b1);
    end
    next_cycle();   // count is 6 in this cycle
    rst = 1'b0;
    settle();
    check("rdiv_rst_md_busy", md_busy, 1'b0);
    check("rdiv_rst_pc_en", pc_en, 1'b0);
    next_cycle();
    rst = 1'b1; id_is_md = 1'b1;
    settle();
    check("rdiv_after_pc_en", pc_en, 1'b1);
    check("rdiv_after_id_ex_flush", id_ex_flush, 1'b0);
    next_cycle(); settle();
    check("rdiv_after2_md_busy", md_busy, 1'b0);
    check("rdiv_after2_pc_en", pc_en, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
